// File: rtl/sd_fifo_sched.sv
// SD-side channel scheduler for the four-channel SD/Wishbone FIFO: round-robin
// grants with bounded bursts, plus a 2-entry return buffer per read channel.
module sd_fifo_sched #(
    parameter int BURST_LEN = 4,
    parameter int DW        = 8
) (
    input  logic          sd_clk,
    input  logic          rst,
    input  logic [1:4]    fifo_full,
    input  logic [1:4]    fifo_empty,
    output logic [1:0]    sd_adr_o,
    output logic          sd_we_o,
    output logic          sd_re_o,
    output logic [DW-1:0] sd_dat_o,
    input  logic [DW-1:0] sd_dat_i,
    output logic [DW-1:0] cmd_tx_dat,
    output logic          cmd_tx_valid,
    input  logic          cmd_tx_ready,
    input  logic [DW-1:0] cmd_rx_dat,
    input  logic          cmd_rx_valid,
    output logic          cmd_rx_ready,
    output logic [DW-1:0] dat_tx_dat,
    output logic          dat_tx_valid,
    input  logic          dat_tx_ready,
    input  logic [DW-1:0] dat_rx_dat,
    input  logic          dat_rx_valid,
    output logic          dat_rx_ready,
    output logic          busy
);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t     state_reg;
    logic [1:0] grant_reg;
    logic [1:0] rr_ptr_reg;
    logic [3:0] burst_cnt_reg;
    logic       busy_reg;
    logic       rd_pend_reg;
    logic [1:0] rd_tag_reg;

    logic [3:0] elig;
    logic       pick_found;
    logic [1:0] pick_ch;
    logic [1:0] scan_idx;
    logic       grant_elig;
    logic       xfer;
    logic       last_xfer;

    // Per read-buffer views; index 0 serves ch0 (cmd), index 1 serves ch2 (dat).
    logic [1:0]         rb_ready;
    logic [1:0]         rb_valid;
    logic [1:0][DW-1:0] rb_dat;
    logic [1:0][1:0]    rb_occ;
    logic [1:0]         rb_infl;

    logic unused_flags;
    assign unused_flags = ^{fifo_full[1], fifo_full[3], fifo_empty[2], fifo_empty[4]};

    assign rb_ready = {dat_tx_ready, cmd_tx_ready};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rbuf
            localparam logic [1:0] CH = 2'(2 * gi);

            logic [DW-1:0] buf_mem [2];
            logic [1:0]    occ_reg;
            logic          rd_ptr_reg;
            logic          wr_ptr_reg;
            logic          infl;
            logic          push;
            logic          pop;
            logic          store;

            assign infl  = rd_pend_reg && (rd_tag_reg == CH);
            assign push  = infl;
            assign pop   = rb_valid[gi] && rb_ready[gi];
            // A word popped the same cycle it returns into an empty buffer bypasses storage.
            assign store = push && !(pop && (occ_reg == 2'd0));

            assign rb_infl[gi]  = infl;
            assign rb_occ[gi]   = occ_reg;
            assign rb_valid[gi] = (occ_reg != 2'd0) || infl;
            assign rb_dat[gi]   = (occ_reg != 2'd0) ? buf_mem[rd_ptr_reg]
                                                    : (infl ? sd_dat_i : '0);

            always_ff @(posedge sd_clk) begin
                if (store) begin
                    buf_mem[wr_ptr_reg] <= sd_dat_i;
                end
            end

            always_ff @(posedge sd_clk or posedge rst) begin
                if (rst) begin
                    occ_reg    <= 2'd0;
                    rd_ptr_reg <= 1'b0;
                    wr_ptr_reg <= 1'b0;
                end else begin
                    if (store) begin
                        wr_ptr_reg <= ~wr_ptr_reg;
                    end
                    if (pop && (occ_reg != 2'd0)) begin
                        rd_ptr_reg <= ~rd_ptr_reg;
                    end
                    occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
                end
            end
        end
    endgenerate

    assign cmd_tx_valid = rb_valid[0];
    assign cmd_tx_dat   = rb_dat[0];
    assign dat_tx_valid = rb_valid[1];
    assign dat_tx_dat   = rb_dat[1];

    // A read channel counts its in-flight word so the buffer can never overflow.
    assign elig[0] = !fifo_empty[1] && (({1'b0, rb_occ[0]} + {2'b00, rb_infl[0]}) < 3'd2);
    assign elig[1] = cmd_rx_valid && !fifo_full[2];
    assign elig[2] = !fifo_empty[3] && (({1'b0, rb_occ[1]} + {2'b00, rb_infl[1]}) < 3'd2);
    assign elig[3] = dat_rx_valid && !fifo_full[4];

    always_comb begin
        pick_found = 1'b0;
        pick_ch    = rr_ptr_reg;
        scan_idx   = 2'd0;
        // Scan farthest-first so the nearest eligible channel from rr_ptr wins.
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_ptr_reg + 2'(k);
            if (elig[scan_idx]) begin
                pick_found = 1'b1;
                pick_ch    = scan_idx;
            end
        end
    end

    assign grant_elig = elig[grant_reg];
    assign xfer       = (state_reg == BURST) && grant_elig;
    assign last_xfer  = (burst_cnt_reg == 4'(BURST_LEN - 1));

    assign sd_re_o      = xfer && !grant_reg[0];
    assign sd_we_o      = xfer && grant_reg[0];
    assign sd_dat_o     = sd_we_o ? (grant_reg[1] ? dat_rx_dat : cmd_rx_dat) : '0;
    assign cmd_rx_ready = sd_we_o && (grant_reg == 2'd1);
    assign dat_rx_ready = sd_we_o && (grant_reg == 2'd3);
    assign sd_adr_o     = grant_reg;
    assign busy         = busy_reg;

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ARB;
            grant_reg     <= 2'd0;
            rr_ptr_reg    <= 2'd0;
            burst_cnt_reg <= 4'd0;
            busy_reg      <= 1'b0;
            rd_pend_reg   <= 1'b0;
            rd_tag_reg    <= 2'd0;
        end else begin
            rd_pend_reg <= sd_re_o;
            rd_tag_reg  <= grant_reg;
            case (state_reg)
                ARB: begin
                    if (pick_found) begin
                        grant_reg     <= pick_ch;
                        burst_cnt_reg <= 4'd0;
                        state_reg     <= BURST;
                        busy_reg      <= 1'b1;
                    end
                end
                BURST: begin
                    if (!grant_elig || last_xfer) begin
                        state_reg  <= ARB;
                        busy_reg   <= 1'b0;
                        rr_ptr_reg <= grant_reg + 2'd1;
                    end else begin
                        burst_cnt_reg <= burst_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= ARB;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
